sna_request_transmitter_param: RTL and testbench
================================================

Name: sna_request_transmitter_param

Overview:
- Parametrised successor to the SNA request-flow transmitter. Sits between the NoC virtual-channel input stage and the AXI4-Lite master channels (AW, W, AR).
- Collects a request packet of header flit, address flit and, for writes, a data flit. Issues the packet as an AXI4-Lite transaction with compliant valid/ready hold rules.
- Records each issued transaction's POV address in an outstanding-ID FIFO, which the response path consumes.

Parameters:
ADDR_WIDTH, 32, AXI address width and address-flit payload width
DATA_WIDTH, 32, AXI data width and data-flit payload width; multiple of 8
POV_WIDTH, 4, POV (return-path) address width
NUM_VC, 8, number of virtual channels; width of is_on_off and is_allocatable
OUTSTANDING, 4, outstanding-ID FIFO depth; power of 2, at least 2

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
is_valid  in  1  flit valid this cycle
read  in  1  header flit: 1 = read request, 0 = write request
vc_id  in  $clog2(NUM_VC)  header flit: VC carrying the packet
pov_addr  in  POV_WIDTH  header flit: return POV address
addr  in  ADDR_WIDTH  address flit payload
data  in  DATA_WIDTH  data flit payload
is_on_off  out  NUM_VC  per-VC flow control; 1 = flit may be sent
is_allocatable  out  NUM_VC  per-VC allocation; 1 = VC may start a packet
araddr, arvalid, arready  out, out, in  ADDR_WIDTH, 1, 1  AXI AR channel
awaddr, awvalid, awready  out, out, in  ADDR_WIDTH, 1, 1  AXI AW channel
wdata, wvalid, wready  out, out, in  DATA_WIDTH, 1, 1  AXI W channel
pov_addr_buffer  out  POV_WIDTH  head of the outstanding-ID FIFO
pov_valid  out  1  outstanding-ID FIFO not empty
pov_pop  in  1  response path consumes the head entry

Behaviour:
- Clock and reset: one clock `clock`. Reset `reset` is synchronous and active-high.
- Values while reset is asserted, and on the first cycle after:
  - state IDLE;
  - all valids 0;
  - araddr, awaddr, wdata 0;
  - FIFO empty, so pov_valid 0 and pov_addr_buffer 0;
  - is_on_off and is_allocatable 0 during reset.
- Reset mid-packet: the packet is discarded; no AXI valid survives.
- Flit acceptance: a flit is accepted when is_valid=1 and is_on_off[vc] is 1 in the same cycle. In IDLE, vc is the incoming vc_id; otherwise it is the locked VC.
- Flow-control outputs are Moore-decoded from registered state:
  - IDLE: is_allocatable and is_on_off all ones.
  - ADDR, DATA: is_allocatable=0; is_on_off has only the locked VC's bit set.
  - W_ISSUE, AR_ISSUE: both outputs all zeros.
- State machine:
  - IDLE: on accept, latch read, pov_addr and vc_id (the locked VC), then go to ADDR.
  - ADDR: on accept, latch addr. Go to AR_ISSUE if read, else to DATA.
  - DATA: on accept, latch data, then go to W_ISSUE.
  - W_ISSUE:
    - On entry, awvalid and wvalid are set in the first cycle the FIFO is not full. awaddr and wdata are driven from the latches.
    - Each valid holds until its own handshake (valid && ready). AW and W complete independently, in either order or in the same cycle; each valid drops the cycle after its own handshake.
    - When both have completed, push the POV and go to IDLE.
  - AR_ISSUE: arvalid is set when the FIFO is not full and holds until arready; then push the POV and go to IDLE.
- Issue latency: the first valid rises one cycle after the final flit is accepted, provided the FIFO is not full. The next packet can be accepted in the cycle after the push.
- Address and data outputs are stable while their valid is high. A valid never deasserts without its handshake.
- Outstanding-ID FIFO:
  - Registered, OUTSTANDING entries; pointers wrap modulo OUTSTANDING; count ranges 0..OUTSTANDING.
  - The slot is guaranteed on entry to an issue state: no other push can occur and pops only free space.
  - Push and pop in the same cycle leaves count unchanged; this also holds at full.
  - pov_pop while empty is ignored.
  - pov_addr_buffer shows the head entry whenever pov_valid=1.
- Full FIFO: the issue state waits with all valids at 0 until a pop frees an entry.

Optional Feature:
- Macro: SNA_WSTRB_EN.
- When defined:
  - adds input strb [DATA_WIDTH/8] and output wstrb [DATA_WIDTH/8];
  - strb is latched with the data flit;
  - wstrb is driven with wdata and held with wvalid;
  - wstrb resets to 0.
- When undefined: neither port exists, and downstream treats all byte lanes as written.

Test Plan:
- Write, single VC: vc_id=3, pov=0x5, addr=0x1000, data=0xDEADBEEF; awready=wready=1. Expect:
  - is_on_off=0x08 in ADDR and DATA;
  - awvalid=wvalid=1 for one cycle with awaddr=0x1000 and wdata=0xDEADBEEF;
  - pov_valid=1 with pov_addr_buffer=0x5;
  - return to IDLE with is_allocatable=0xFF.
- Read with stalled arready: addr=0x2004, arready held 0 for 3 cycles. Expect:
  - arvalid held high with araddr=0x2004 throughout;
  - a single push after arready=1.
- Split W/AW handshake: awready=1 at cycle 0 and wready=1 at cycle 2. Expect awvalid to drop after cycle 0, wvalid to drop after cycle 2, and exactly one push.
- FIFO full: issue OUTSTANDING=4 reads with no pov_pop, then a fifth. Expect:
  - arvalid stays 0 for the fifth read;
  - pov_pop=1 lets arvalid rise the next cycle;
  - the head POV order is preserved.
- Reset in W_ISSUE with awvalid=1. The next cycle, all valids=0, the FIFO is empty, and a new packet completes normally.
- SNA_WSTRB_EN defined: strb=0x3 on the data flit. Expect wstrb=0x3 while wvalid=1, and wstrb=0 after reset.

Source files
------------

// File: rtl/sna_request_transmitter_param_if.sv
// rtl/sna_request_transmitter_param_if.sv - AXI4-Lite AW/W/AR request channel bundle
// Signals: awaddr/awvalid/awready, wdata/wvalid/wready (+ wstrb when SNA_WSTRB_EN),
//          araddr/arvalid/arready.
// Modports: master = request transmitter (drives addr/data/valid), slave = AXI target.
// Optional macro: SNA_WSTRB_EN adds the wstrb byte-lane vector.
interface sna_request_transmitter_param_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    wvalid;
   logic                    wready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
`ifdef SNA_WSTRB_EN
   logic [DATA_WIDTH/8-1:0] wstrb;

   modport master (output awaddr, awvalid, wdata, wvalid, wstrb, araddr, arvalid,
                   input  awready, wready, arready);
   modport slave  (input  awaddr, awvalid, wdata, wvalid, wstrb, araddr, arvalid,
                   output awready, wready, arready);
`else
   modport master (output awaddr, awvalid, wdata, wvalid, araddr, arvalid,
                   input  awready, wready, arready);
   modport slave  (input  awaddr, awvalid, wdata, wvalid, araddr, arvalid,
                   output awready, wready, arready);
`endif
endinterface

// File: rtl/sna_request_transmitter_param.sv
// rtl/sna_request_transmitter_param.sv - SNA request flits to AXI4-Lite AW/W/AR transactions
// Ports: clock, reset (sync, active-high); flit inputs is_valid/read/vc_id/pov_addr/addr/data
//        (+ strb when SNA_WSTRB_EN); per-VC flow control is_on_off/is_allocatable;
//        axi (master modport: AW, W, AR channels); outstanding-ID FIFO head
//        pov_addr_buffer/pov_valid with consume strobe pov_pop.
// Optional macro: SNA_WSTRB_EN latches strb with the data flit and drives axi.wstrb.
module sna_request_transmitter_param #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int POV_WIDTH   = 4,
   parameter int NUM_VC      = 8,
   parameter int OUTSTANDING = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        is_valid,
   input  logic                        read,
   input  logic [$clog2(NUM_VC)-1:0]   vc_id,
   input  logic [POV_WIDTH-1:0]        pov_addr,
   input  logic [ADDR_WIDTH-1:0]       addr,
   input  logic [DATA_WIDTH-1:0]       data,
`ifdef SNA_WSTRB_EN
   input  logic [DATA_WIDTH/8-1:0]     strb,
`endif
   output logic [NUM_VC-1:0]           is_on_off,
   output logic [NUM_VC-1:0]           is_allocatable,
   sna_request_transmitter_param_if.master axi,
   output logic [POV_WIDTH-1:0]        pov_addr_buffer,
   output logic                        pov_valid,
   input  logic                        pov_pop
);
   localparam int VC_W  = $clog2(NUM_VC);
   localparam int PTR_W = $clog2(OUTSTANDING);
   localparam int CNT_W = $clog2(OUTSTANDING + 1);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_W_ISSUE, S_AR_ISSUE} state_t;

   state_t                  state, state_nxt;
   logic                    rd_q;
   logic [VC_W-1:0]         vc_q;
   logic [POV_WIDTH-1:0]    pov_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    aw_done, w_done;
   logic                    ar_v, aw_v, w_v;
   logic                    accept, push, pop, fifo_full;
   logic                    aw_hs, w_hs, ar_hs;
   logic [VC_W-1:0]         vc_sel;

   logic [POV_WIDTH-1:0]    mem [OUTSTANDING];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [CNT_W-1:0]        count;

   assign fifo_full = (count == CNT_W'(OUTSTANDING));
   assign vc_sel    = (state == S_IDLE) ? vc_id : vc_q;
   assign aw_hs     = aw_v && axi.awready;
   assign w_hs      = w_v && axi.wready;
   assign ar_hs     = ar_v && axi.arready;
   assign pop       = pov_pop && (count != '0);

   // Flow control and valids are decoded from registered state only; the FIFO
   // can only drain while an issue state waits, so once not full it stays so.
   always_comb begin
      state_nxt      = state;
      is_on_off      = '0;
      is_allocatable = '0;
      ar_v           = 1'b0;
      aw_v           = 1'b0;
      w_v            = 1'b0;
      push           = 1'b0;
      if (!reset) begin
         unique case (state)
            S_IDLE: begin
               is_on_off      = '1;
               is_allocatable = '1;
            end
            S_ADDR, S_DATA: is_on_off = NUM_VC'(1) << vc_q;
            S_W_ISSUE: begin
               aw_v = !aw_done && !fifo_full;
               w_v  = !w_done && !fifo_full;
            end
            S_AR_ISSUE: ar_v = !fifo_full;
            default: ;
         endcase
      end
      accept = is_valid && is_on_off[vc_sel];
      if (!reset) begin
         unique case (state)
            S_IDLE:  if (accept) state_nxt = S_ADDR;
            S_ADDR:  if (accept) state_nxt = rd_q ? S_AR_ISSUE : S_DATA;
            S_DATA:  if (accept) state_nxt = S_W_ISSUE;
            S_W_ISSUE: begin
               // AW and W may finish in either order or together.
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  push      = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            S_AR_ISSUE: begin
               if (ar_hs) begin
                  push      = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         rd_q    <= 1'b0;
         vc_q    <= '0;
         pov_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && accept) begin
            rd_q    <= read;
            vc_q    <= vc_id;
            pov_q   <= pov_addr;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (state == S_ADDR && accept) addr_q <= addr;
         if (state == S_DATA && accept) data_q <= data;
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= pov_q;
   end

`ifdef SNA_WSTRB_EN
   logic [DATA_WIDTH/8-1:0] strb_q;
   always_ff @(posedge clock) begin
      if (reset)                          strb_q <= '0;
      else if (state == S_DATA && accept) strb_q <= strb;
   end
   assign axi.wstrb = reset ? '0 : strb_q;
`endif

   assign axi.arvalid     = ar_v;
   assign axi.awvalid     = aw_v;
   assign axi.wvalid      = w_v;
   assign axi.araddr      = reset ? '0 : addr_q;
   assign axi.awaddr      = reset ? '0 : addr_q;
   assign axi.wdata       = reset ? '0 : data_q;
   assign pov_valid       = !reset && (count != '0);
   assign pov_addr_buffer = pov_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_sna_request_transmitter_param.sv
// tb/tb_sna_request_transmitter_param.sv - self-checking bench for sna_request_transmitter_param
module tb_sna_request_transmitter_param;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int PW = 4;
   localparam int NV = 8;
   localparam int OS = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          is_valid, read, pov_pop;
   logic [2:0]    vc_id;
   logic [PW-1:0] pov_addr;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic [NV-1:0] is_on_off, is_allocatable;
   logic [PW-1:0] pov_addr_buffer;
   logic          pov_valid;
`ifdef SNA_WSTRB_EN
   logic [DW/8-1:0] strb;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   sna_request_transmitter_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   sna_request_transmitter_param #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POV_WIDTH(PW), .NUM_VC(NV), .OUTSTANDING(OS)
   ) dut (
      .clock(clock), .reset(reset), .is_valid(is_valid), .read(read), .vc_id(vc_id),
      .pov_addr(pov_addr), .addr(addr), .data(data),
`ifdef SNA_WSTRB_EN
      .strb(strb),
`endif
      .is_on_off(is_on_off), .is_allocatable(is_allocatable), .axi(axi),
      .pov_addr_buffer(pov_addr_buffer), .pov_valid(pov_valid), .pov_pop(pov_pop)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Packet-level model: how many flits of the current packet are in, whether
   // it is being issued, which AXI handshakes it still owes, and the POV queue.
   int            m_flits;
   bit            m_issuing, m_rd, m_aw_pend, m_w_pend;
   logic [2:0]    m_vc;
   logic [PW-1:0] m_pov;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [DW/8-1:0] m_strb;
   logic [PW-1:0] mq [$];

   function automatic bit room();
      return mq.size() < OS;
   endfunction
   function automatic bit exp_ar();
      return !reset && m_issuing && m_rd && room();
   endfunction
   function automatic bit exp_aw();
      return !reset && m_issuing && !m_rd && m_aw_pend && room();
   endfunction
   function automatic bit exp_w();
      return !reset && m_issuing && !m_rd && m_w_pend && room();
   endfunction
   function automatic logic [NV-1:0] exp_on_off();
      if (reset || m_issuing) return '0;
      if (m_flits == 0) return '1;
      return NV'(1) << m_vc;
   endfunction
   function automatic logic [NV-1:0] exp_alloc();
      return (!reset && !m_issuing && m_flits == 0) ? '1 : '0;
   endfunction

   initial begin
      m_flits = 0; m_issuing = 0; m_rd = 0; m_aw_pend = 0; m_w_pend = 0;
      m_vc = '0; m_pov = '0; m_addr = '0; m_data = '0; m_strb = '0;
      forever begin
         @(posedge clock);
         if (reset) begin
            m_flits = 0; m_issuing = 0; m_aw_pend = 0; m_w_pend = 0;
            m_addr = '0; m_data = '0; m_strb = '0;
            mq.delete();
         end else begin
            bit ar_e, aw_e, w_e, acc;
            logic [NV-1:0] oo;
            ar_e = exp_ar(); aw_e = exp_aw(); w_e = exp_w(); oo = exp_on_off();
            acc  = is_valid && oo[(m_flits == 0) ? vc_id : m_vc];
            if (pov_pop && mq.size() > 0) void'(mq.pop_front());
            if (m_issuing) begin
               if (m_rd) begin
                  if (ar_e && axi.arready) begin
                     mq.push_back(m_pov); m_issuing = 0; m_flits = 0;
                  end
               end else begin
                  if (aw_e && axi.awready) m_aw_pend = 0;
                  if (w_e && axi.wready)   m_w_pend = 0;
                  if (!m_aw_pend && !m_w_pend) begin
                     mq.push_back(m_pov); m_issuing = 0; m_flits = 0;
                  end
               end
            end else if (acc) begin
               if (m_flits == 0) begin
                  m_rd = read; m_vc = vc_id; m_pov = pov_addr; m_flits = 1;
               end else if (m_flits == 1) begin
                  m_addr = addr;
                  if (m_rd) m_issuing = 1;
                  else      m_flits = 2;
               end else begin
                  m_data = data;
`ifdef SNA_WSTRB_EN
                  m_strb = strb;
`endif
                  m_issuing = 1; m_aw_pend = 1; m_w_pend = 1;
               end
            end
         end
      end
   end

   // Per-cycle comparison of every meaningful output against the model.
   initial begin
      forever begin
         @(negedge clock);
         chk("arvalid", axi.arvalid, exp_ar());
         chk("awvalid", axi.awvalid, exp_aw());
         chk("wvalid", axi.wvalid, exp_w());
         chk("is_on_off", is_on_off, exp_on_off());
         chk("is_allocatable", is_allocatable, exp_alloc());
         chk("pov_valid", pov_valid, !reset && mq.size() > 0);
         if (!reset && mq.size() > 0) chk("pov_addr_buffer", pov_addr_buffer, mq[0]);
         if (exp_ar()) chk("araddr", axi.araddr, m_addr);
         if (exp_aw()) chk("awaddr", axi.awaddr, m_addr);
         if (exp_w())  chk("wdata", axi.wdata, m_data);
`ifdef SNA_WSTRB_EN
         if (exp_w())  chk("wstrb", axi.wstrb, m_strb);
`endif
         if (reset) begin
            chk("rst_awaddr", axi.awaddr, 0);
            chk("rst_wdata", axi.wdata, 0);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drives header, address and (for writes) data flits on consecutive cycles;
   // returns in the first issue cycle with is_valid low.
   task automatic send_pkt(input bit rd, input logic [2:0] vc, input logic [PW-1:0] pov,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      is_valid = 1; read = rd; vc_id = vc; pov_addr = pov;
      step();
      addr = a;
      step();
      if (!rd) begin
         data = d;
         step();
      end
      is_valid = 0;
   endtask

   logic [PW-1:0] order [4] = '{4'h2, 4'h3, 4'h4, 4'h6};

   initial begin
      reset = 1; is_valid = 0; read = 0; vc_id = '0; pov_addr = '0; addr = '0; data = '0;
      pov_pop = 0; axi.awready = 0; axi.wready = 0; axi.arready = 0;
`ifdef SNA_WSTRB_EN
      strb = '0;
`endif
      step(); step();
      @(negedge clock);
      chk("lit_rst_on_off", is_on_off, 8'h00);
      chk("lit_rst_pov_valid", pov_valid, 0);
      reset = 0;
      step();
      @(negedge clock);
      chk("lit_idle_alloc", is_allocatable, 8'hFF);
      chk("lit_idle_awaddr", axi.awaddr, 0);
`ifdef SNA_WSTRB_EN
      chk("lit_rst_wstrb", axi.wstrb, 0);
`endif

      // Write on VC 3, both readies high.
      step();
      axi.awready = 1; axi.wready = 1;
      is_valid = 1; read = 0; vc_id = 3'd3; pov_addr = 4'h5;
      step();
      addr = 32'h1000;
      @(negedge clock);
      chk("lit_w_onoff_addr", is_on_off, 8'h08);
      chk("lit_w_alloc_addr", is_allocatable, 8'h00);
      step();
      data = 32'hDEADBEEF;
`ifdef SNA_WSTRB_EN
      strb = 4'h3;
`endif
      @(negedge clock);
      chk("lit_w_onoff_data", is_on_off, 8'h08);
      step();
      is_valid = 0;
      @(negedge clock);
      chk("lit_w_awvalid", axi.awvalid, 1);
      chk("lit_w_wvalid", axi.wvalid, 1);
      chk("lit_w_awaddr", axi.awaddr, 32'h1000);
      chk("lit_w_wdata", axi.wdata, 32'hDEADBEEF);
`ifdef SNA_WSTRB_EN
      chk("lit_w_wstrb", axi.wstrb, 4'h3);
`endif
      step();
      @(negedge clock);
      chk("lit_w_awvalid_drop", axi.awvalid, 0);
      chk("lit_w_pov_valid", pov_valid, 1);
      chk("lit_w_pov_head", pov_addr_buffer, 4'h5);
      chk("lit_w_alloc_idle", is_allocatable, 8'hFF);
      pov_pop = 1;
      step();
      pov_pop = 0;

      // Read with arready stalled three cycles.
      axi.arready = 0;
      send_pkt(1, 3'd1, 4'h9, 32'h2004, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("lit_r_arvalid_stall", axi.arvalid, 1);
         chk("lit_r_araddr_stall", axi.araddr, 32'h2004);
         step();
      end
      axi.arready = 1;
      step();
      axi.arready = 0;
      @(negedge clock);
      chk("lit_r_arvalid_drop", axi.arvalid, 0);
      chk("lit_r_pov_head", pov_addr_buffer, 4'h9);
      pov_pop = 1;
      step();
      pov_pop = 0;
      @(negedge clock);
      chk("lit_r_single_push", pov_valid, 0);

      // Split AW/W handshake.
      axi.awready = 1; axi.wready = 0;
      send_pkt(0, 3'd5, 4'hA, 32'h3000, 32'h12345678);
      step();
      axi.awready = 0;
      @(negedge clock);
      chk("lit_s_awvalid_c1", axi.awvalid, 0);
      chk("lit_s_wvalid_c1", axi.wvalid, 1);
      step();
      axi.wready = 1;
      step();
      axi.wready = 0;
      @(negedge clock);
      chk("lit_s_wvalid_drop", axi.wvalid, 0);
      chk("lit_s_pov_head", pov_addr_buffer, 4'hA);
      pov_pop = 1;
      step();
      pov_pop = 0;
      @(negedge clock);
      chk("lit_s_single_push", pov_valid, 0);

      // Fill the FIFO with four reads, then a fifth must wait for a pop.
      axi.arready = 1;
      for (int k = 1; k <= 4; k++) begin
         send_pkt(1, 3'(k), 4'(k), 32'(k * 256), '0);
         step();
      end
      @(negedge clock);
      chk("lit_f_head_first", pov_addr_buffer, 4'h1);
      send_pkt(1, 3'd6, 4'h6, 32'h600, '0);
      @(negedge clock);
      chk("lit_f_arvalid_full0", axi.arvalid, 0);
      step();
      @(negedge clock);
      chk("lit_f_arvalid_full1", axi.arvalid, 0);
      pov_pop = 1;
      step();
      pov_pop = 0;
      @(negedge clock);
      chk("lit_f_arvalid_rise", axi.arvalid, 1);
      chk("lit_f_head_after_pop", pov_addr_buffer, 4'h2);
      step();
      pov_pop = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("lit_f_order", pov_addr_buffer, order[i]);
         step();
      end
      pov_pop = 0;
      @(negedge clock);
      chk("lit_f_drained", pov_valid, 0);

      // Reset while a write sits in its issue state.
      send_pkt(1, 3'd2, 4'h7, 32'h700, '0);
      step();
      axi.awready = 0; axi.wready = 0;
      send_pkt(0, 3'd4, 4'hC, 32'h800, 32'h0000CAFE);
      @(negedge clock);
      chk("lit_x_awvalid_pre", axi.awvalid, 1);
      reset = 1;
      step();
      reset = 0;
      @(negedge clock);
      chk("lit_x_awvalid_post", axi.awvalid, 0);
      chk("lit_x_wvalid_post", axi.wvalid, 0);
      chk("lit_x_pov_valid_post", pov_valid, 0);
      chk("lit_x_awaddr_post", axi.awaddr, 0);
`ifdef SNA_WSTRB_EN
      chk("lit_x_wstrb_post", axi.wstrb, 0);
`endif
      axi.awready = 1; axi.wready = 1;
      send_pkt(0, 3'd0, 4'hE, 32'h900, 32'h0000BEEF);
      @(negedge clock);
      chk("lit_x_new_awaddr", axi.awaddr, 32'h900);
      chk("lit_x_new_wdata", axi.wdata, 32'h0000BEEF);
      step();
      @(negedge clock);
      chk("lit_x_new_pov", pov_addr_buffer, 4'hE);
      pov_pop = 1;
      step();
      pov_pop = 0;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
